// File: rtl/cache_array_pkg.sv
// Shared types and helpers for the N-way cache data array.
// Imported by the bank and the top-level array.
package cache_array_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/cache_array_bank.sv
// One way of the data array: SETS lines, per-granule masked write,
// registered read that holds its value until the next read.
module cache_array_bank
   import cache_array_pkg::*;
#(
   parameter  int SETS       = 16,
   parameter  int DATA_WIDTH = 256,
   parameter  int WMASK_GRAN = 8,
   localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN,
   localparam int SET_W      = $clog2(SETS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic                  re,
   input  logic [SET_W-1:0]      idx,
   input  logic [NUM_WMASKS-1:0] wmask,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [SETS];

   // Storage is never reset; zero-fill is done by the owner's INIT sweep.
   always_ff @(posedge clk) begin
      for (int g = 0; g < NUM_WMASKS; g++) begin
         if (we && wmask[g])
            mem[idx][g*WMASK_GRAN +: WMASK_GRAN] <= wdata[g*WMASK_GRAN +: WMASK_GRAN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rdata <= '0;
      else if (re)
         rdata <= mem[idx];
   end

endmodule

// File: rtl/cache_data_array_nway.sv
// N-way byte-maskable 1RW cache data array with valid/ready requests,
// fixed read latency and a zero-fill clear sequencer.
module cache_data_array_nway
   import cache_array_pkg::*;
#(
   parameter  int NUM_WAYS      = 2,
   parameter  int SETS          = 16,
   parameter  int DATA_WIDTH    = 256,
   parameter  int WMASK_GRAN    = 8,
   parameter  int READ_LAT      = 1,
   parameter  int INIT_ON_RESET = 1,
   localparam int NUM_WMASKS    = DATA_WIDTH / WMASK_GRAN,
   localparam int WAY_W         = way_bits(NUM_WAYS),
   localparam int SET_W         = $clog2(SETS)
) (
   input  logic                  clk0,
   input  logic                  rst0_n,
   input  logic                  clear,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [SET_W-1:0]      req_set,
   input  logic [WAY_W-1:0]      req_way,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  init_done
);

   state_t                state;
   logic [SET_W-1:0]      cnt;
   logic                  accept;
   logic                  init_wr;
   logic [SET_W-1:0]      bank_idx;
   logic [NUM_WMASKS-1:0] bank_wmask;
   logic [DATA_WIDTH-1:0] bank_wdata;
   logic [DATA_WIDTH-1:0] bank_rdata [NUM_WAYS];
   logic                  v0;
   logic [WAY_W-1:0]      way0;
   logic [DATA_WIDTH-1:0] d0;

   assign init_wr   = (state == ST_INIT);
   assign init_done = (state == ST_READY);
   assign req_ready = (state == ST_READY) && !clear;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
         cnt   <= '0;
      end else if (clear) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else if (state == ST_INIT) begin
         cnt <= cnt + SET_W'(1);
         if (cnt == SET_W'(SETS - 1))
            state <= ST_READY;
      end
   end

   // The INIT sweep borrows the single port of every way at once.
   assign bank_idx   = init_wr ? cnt : req_set;
   assign bank_wmask = init_wr ? '1 : req_wmask;
   assign bank_wdata = init_wr ? '0 : req_wdata;

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      logic sel;
      assign sel = accept && (req_way == WAY_W'(w));
      cache_array_bank #(
         .SETS       (SETS),
         .DATA_WIDTH (DATA_WIDTH),
         .WMASK_GRAN (WMASK_GRAN)
      ) u_bank (
         .clk   (clk0),
         .rst_n (rst0_n),
         .we    (init_wr || (sel && req_we)),
         .re    (sel && !req_we),
         .idx   (bank_idx),
         .wmask (bank_wmask),
         .wdata (bank_wdata),
         .rdata (bank_rdata[w])
      );
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         v0   <= 1'b0;
         way0 <= '0;
      end else begin
         v0 <= accept && !req_we;
         if (accept && !req_we)
            way0 <= req_way;
      end
   end

   // Out-of-range ways fall through to zero.
   always_comb begin
      d0 = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (way0 == WAY_W'(w))
            d0 = bank_rdata[w];
      end
   end

   for (genvar s = 1; s < READ_LAT; s++) begin : g_pipe
      logic                  v;
      logic [DATA_WIDTH-1:0] d;
      logic                  vin;
      logic [DATA_WIDTH-1:0] din;
      if (s == 1) begin : g_first
         assign vin = v0;
         assign din = d0;
      end else begin : g_next
         assign vin = g_pipe[s-1].v;
         assign din = g_pipe[s-1].d;
      end
      always_ff @(posedge clk0 or negedge rst0_n) begin
         if (!rst0_n) begin
            v <= 1'b0;
            d <= '0;
         end else begin
            v <= vin;
            if (vin)
               d <= din;
         end
      end
   end

   if (READ_LAT == 1) begin : g_out1
      assign rsp_valid = v0;
      assign rsp_data  = d0;
   end else begin : g_outn
      assign rsp_valid = g_pipe[READ_LAT-1].v;
      assign rsp_data  = g_pipe[READ_LAT-1].d;
   end

endmodule

// File: tb/tb_cache_data_array_nway.sv
// Randomised and directed bench for cache_data_array_nway against a
// line-array reference model with a timed response queue.
module tb_cache_data_array_nway;

   localparam int NW   = 3;
   localparam int SETS = 16;
   localparam int DW   = 256;
   localparam int GR   = 8;
   localparam int NM   = DW / GR;
   localparam int LAT  = 3;

   logic          clk0 = 1'b0;
   logic          rst0_n = 1'b0;
   logic          clear = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [3:0]    req_set = '0;
   logic [1:0]    req_way = '0;
   logic [NM-1:0] req_wmask = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          init_done;

   always #5 clk0 = ~clk0;

   cache_data_array_nway #(
      .NUM_WAYS      (NW),
      .SETS          (SETS),
      .DATA_WIDTH    (DW),
      .WMASK_GRAN    (GR),
      .READ_LAT      (LAT),
      .INIT_ON_RESET (1)
   ) dut (
      .clk0      (clk0),
      .rst0_n    (rst0_n),
      .clear     (clear),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_set   (req_set),
      .req_way   (req_way),
      .req_wmask (req_wmask),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .init_done (init_done)
   );

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } rsp_t;

   rsp_t          q[$];
   logic [DW-1:0] model [NW][SETS];
   logic [DW-1:0] last;
   int            init_left;
   int            cycle;
   int            checks;
   int            errors;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got %h exp %h", tag, cycle, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last = '0;
      init_left = SETS;
      for (int w = 0; w < NW; w++)
         for (int s = 0; s < SETS; s++)
            model[w][s] = '0;
   endtask

   task automatic check_outputs();
      logic ev;
      rsp_t r;
      ev = (q.size() > 0) && (q[0].due == cycle);
      if (ev) begin
         r = q.pop_front();
         last = r.d;
      end
      chk("rsp_valid", DW'(rsp_valid), DW'(ev));
      chk("rsp_data", rsp_data, last);
      chk("init_done", DW'(init_done), DW'(init_left == 0));
   endtask

   task automatic cyc(input logic v, input logic we, input logic [1:0] way,
                      input logic [3:0] set, input logic [NM-1:0] m,
                      input logic [DW-1:0] d, input logic clr);
      logic rdy;
      logic [DW-1:0] rd;
      req_valid = v;
      req_we    = we;
      req_way   = way;
      req_set   = set;
      req_wmask = m;
      req_wdata = d;
      clear     = clr;
      rdy = (init_left == 0) && !clr;
      #1;
      chk("req_ready", DW'(req_ready), DW'(rdy));
      if (v && rdy) begin
         if (we) begin
            if (way < NW)
               for (int g = 0; g < NM; g++)
                  if (m[g])
                     model[way][set][g*GR +: GR] = d[g*GR +: GR];
         end else begin
            rd = (way < NW) ? model[way][set] : '0;
            q.push_back('{cycle + LAT, rd});
         end
      end
      if (clr) begin
         init_left = SETS;
         for (int w = 0; w < NW; w++)
            for (int s = 0; s < SETS; s++)
               model[w][s] = '0;
      end else if (init_left > 0) begin
         init_left--;
      end
      @(posedge clk0);
      cycle++;
      @(negedge clk0);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b0, 2'd0, 4'd0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [1:0] way, input logic [3:0] set);
      cyc(1'b1, 1'b0, way, set, '0, '0, 1'b0);
   endtask

   task automatic wr(input logic [1:0] way, input logic [3:0] set,
                     input logic [NM-1:0] m, input logic [DW-1:0] d);
      cyc(1'b1, 1'b1, way, set, m, d, 1'b0);
   endtask

   task automatic clr_pulse();
      cyc(1'b0, 1'b0, 2'd0, 4'd0, '0, '0, 1'b1);
   endtask

   task automatic read_all();
      for (int w = 0; w < NW; w++)
         for (int s = 0; s < SETS; s++)
            rd(2'(w), 4'(s));
      idle(LAT + 1);
   endtask

   initial begin
      logic [DW-1:0] dv;
      checks = 0;
      errors = 0;
      cycle  = 0;
      model_reset();

      @(posedge clk0);
      #1;
      chk("rst_ready", DW'(req_ready), '0);
      chk("rst_valid", DW'(rsp_valid), '0);
      chk("rst_data", rsp_data, '0);
      chk("rst_init_done", DW'(init_done), '0);
      @(negedge clk0);
      rst0_n = 1'b1;

      idle(17);
      read_all();

      wr(2'd1, 4'd5, '1, {32{8'hA5}});
      rd(2'd1, 4'd5);
      rd(2'd0, 4'd5);
      idle(LAT + 1);

      wr(2'd0, 4'd3, '1, {32{8'hFF}});
      wr(2'd0, 4'd3, 32'h0000_0001, '0);
      rd(2'd0, 4'd3);
      idle(LAT + 1);

      for (int s = 0; s < 8; s++)
         wr(2'd2, 4'(s), '1, {8{$urandom()}});
      for (int s = 0; s < 8; s++)
         rd(2'd2, 4'(s));
      idle(LAT + 2);

      wr(2'd0, 4'd2, '1, {8{$urandom()}});
      wr(2'd3, 4'd2, '1, {8{$urandom()}});
      rd(2'd3, 4'd2);
      rd(2'd0, 4'd2);
      idle(LAT + 1);

      for (int i = 0; i < 400; i++) begin
         dv = {8{$urandom()}};
         cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, SETS - 1)),
             NM'($urandom()), dv, $urandom_range(0, 99) == 0);
      end
      idle(SETS + LAT + 1);

      rd(2'd1, 4'd5);
      rd(2'd0, 4'd3);
      clr_pulse();
      idle(SETS);
      read_all();

      clr_pulse();
      idle(10);
      clr_pulse();
      idle(SETS);
      rd(2'd1, 4'd1);
      idle(LAT + 1);

      wr(2'd1, 4'd7, '1, {32{8'h3C}});
      rd(2'd1, 4'd7);
      rst0_n = 1'b0;
      #1;
      chk("midrst_valid", DW'(rsp_valid), '0);
      chk("midrst_data", rsp_data, '0);
      chk("midrst_ready", DW'(req_ready), '0);
      model_reset();
      @(negedge clk0);
      @(negedge clk0);
      rst0_n = 1'b1;
      idle(SETS + 1);
      idle(LAT + 2);
      read_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
